falafel_lsu_burst: RTL and testbench
====================================

FALAFEL_LSU_BURST -- requirements
Module: falafel_lsu_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter BLOCK_WORDS, default 2, words per block transfer; legal range 1..16.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, maximum issued-but-unanswered memory requests; legal range 1..8.
REQ-004 SHALL have ports, in this order:
- clk_i  in  1  sole clock; all state is updated on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- alloc_req_val_i  in  1  request valid.
- alloc_req_rdy_o  out  1  request ready.
- alloc_req_op_i  in  lsu_op_e  LOAD_WORD / STORE_WORD / LOAD_BLOCK / STORE_BLOCK.
- alloc_req_addr_i  in  DATA_W  byte address.
- alloc_req_word_i  in  DATA_W  store data for STORE_WORD.
- alloc_req_block_i  in  BLOCK_WORDS*DATA_W  store data for STORE_BLOCK; word k occupies bits [k*DATA_W +: DATA_W].
- alloc_rsp_val_o  out  1  response valid.
- alloc_rsp_rdy_i  in  1  response ready.
- alloc_rsp_word_o  out  DATA_W  data returned by LOAD_WORD.
- alloc_rsp_block_o  out  BLOCK_WORDS*DATA_W  data returned by LOAD_BLOCK.
- alloc_rsp_err_o  out  1  misaligned-address error.
- mem_req_val_o  out  1  memory request valid.
- mem_req_rdy_i  in  1  memory request ready.
- mem_req_is_write_o  out  1  1 = write, 0 = read.
- mem_req_addr_o  out  DATA_W  memory byte address.
- mem_req_data_o  out  DATA_W  memory write data.
- mem_rsp_val_i  in  1  memory response valid.
- mem_rsp_rdy_o  out  1  memory response ready.
- mem_rsp_data_i  in  DATA_W  memory response data.

Function
REQ-005 SHALL implement the states IDLE, ISSUE, DRAIN and RESPOND.
REQ-006 IDLE: alloc_req_rdy_o=1; on alloc_req_val_i, SHALL latch op, address and store data, load the beat count (1 for word ops, BLOCK_WORDS for block ops), and go to ISSUE.
REQ-007 ISSUE: mem_req_val_o=1 while issued<beats and outstanding<MAX_OUTSTANDING; mem_req_addr_o = base + issued*(DATA_W/8), arithmetic modulo 2^DATA_W.
REQ-008 Write ops SHALL drive mem_req_data_o with word[issued]; read ops SHALL drive 0.
REQ-009 Every memory request, read or write, SHALL receive exactly one in-order response.
- mem_rsp_rdy_o=1 in ISSUE and DRAIN only.
REQ-010 Read responses SHALL be written to result word[received], then received is incremented.
REQ-011 Counter updates on a request handshake and a response handshake in the same cycle:
- outstanding unchanged; issued and received each incremented.
REQ-012 ISSUE SHALL go to DRAIN when issued==beats; DRAIN SHALL go to RESPOND when received==beats.
- If both conditions become true in the same cycle, ISSUE SHALL go directly to RESPOND.
REQ-013 RESPOND: alloc_rsp_val_o=1 with stable data until alloc_rsp_rdy_i=1, then go to IDLE.
REQ-014 Minimum latency with a zero-wait memory: request accepted in cycle 0, first mem request in cycle 1, LOAD_WORD response valid in cycle 3.
REQ-015 LOAD_BLOCK with MAX_OUTSTANDING>=2 SHALL issue back-to-back requests (one per cycle) when mem_req_rdy_i stays high.
REQ-016 Store ops SHALL return alloc_rsp_word_o/alloc_rsp_block_o unchanged from the previous load.
REQ-017 An illegal op SHALL be treated as LOAD_WORD (simulation assertion fires).

Reset
REQ-018 rst_ni low SHALL immediately force IDLE and clear all counters, buffers and results to 0.
- All outputs read 0, except alloc_req_rdy_o=1 once in IDLE.
REQ-019 Reset mid-transfer SHALL abandon the transfer.
- Memory responses arriving later are not accepted (mem_rsp_rdy_o=0 in IDLE).

Configuration
REQ-020 Macro FALAFEL_LSU_ALIGN_CHECK_EN, when defined:
- A request whose addr[log2(DATA_W/8)-1:0]!=0 SHALL issue no memory traffic.
- It SHALL go from IDLE to RESPOND with alloc_rsp_err_o=1.
REQ-021 Without the macro, alloc_rsp_err_o SHALL be tied 0 and misaligned addresses SHALL be passed through unchanged.

Verification
REQ-022 LOAD_WORD at 0x100 with a zero-wait memory returning 0xDEADBEEF -> rsp_val in cycle 3, word=0xDEADBEEF.
REQ-023 LOAD_BLOCK at 0x200, BLOCK_WORDS=4, MAX_OUTSTANDING=2:
- Memory answers after 3 cycles -> never more than 2 outstanding.
- Addresses 0x200, 0x204, 0x208, 0x20C; words assembled in order.
REQ-024 STORE_BLOCK at 0xFFFFFFFC, BLOCK_WORDS=2, {0x11,0x22} -> writes 0x11 at 0xFFFFFFFC and 0x22 at 0x0 (wrap), one response.
REQ-025 Random mem_req_rdy_i/mem_rsp_val_i stalls and a simultaneous request/response handshake -> correct data; outstanding never exceeds MAX_OUTSTANDING.
REQ-026 rst_ni asserted after the 2nd beat of a 4-beat load -> IDLE in the same cycle, outputs 0, next request completes normally.
REQ-027 With FALAFEL_LSU_ALIGN_CHECK_EN, LOAD_WORD at 0x102 -> no mem_req_val_o, err=1 one cycle after acceptance.

Source files
------------

// File: rtl/falafel_lsu_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : falafel_lsu_burst (with package falafel_lsu_pkg)
// Purpose  : Load/store unit front end. It accepts one word or block request
//            at a time, splits it into DATA_W-wide memory beats, and keeps at
//            most MAX_OUTSTANDING beats in flight. Read data is assembled in
//            order and then presented as a single response.
// Ports    : clk_i/rst_ni            - clock, async active-low reset
//            alloc_req_*             - request channel (val/rdy, op, addr, data)
//            alloc_rsp_*             - response channel (val/rdy, word, block, err)
//            mem_req_*               - memory request channel (one beat each)
//            mem_rsp_*               - memory response channel (in-order)
// Options  : FALAFEL_LSU_ALIGN_CHECK_EN - when defined, misaligned requests
//            issue no memory traffic and respond with alloc_rsp_err_o=1.
// Revision : 1.0 - initial release
// ============================================================================

package falafel_lsu_pkg;
  // 3-bit encoding leaves spare codes; any spare code behaves as LOAD_WORD.
  typedef enum logic [2:0] {
    LOAD_WORD   = 3'd0,
    STORE_WORD  = 3'd1,
    LOAD_BLOCK  = 3'd2,
    STORE_BLOCK = 3'd3
  } lsu_op_e;
endpackage

module falafel_lsu_burst
  import falafel_lsu_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int BLOCK_WORDS     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          alloc_req_val_i,
  output logic                          alloc_req_rdy_o,
  input  lsu_op_e                       alloc_req_op_i,
  input  logic [DATA_W-1:0]             alloc_req_addr_i,
  input  logic [DATA_W-1:0]             alloc_req_word_i,
  input  logic [BLOCK_WORDS*DATA_W-1:0] alloc_req_block_i,
  output logic                          alloc_rsp_val_o,
  input  logic                          alloc_rsp_rdy_i,
  output logic [DATA_W-1:0]             alloc_rsp_word_o,
  output logic [BLOCK_WORDS*DATA_W-1:0] alloc_rsp_block_o,
  output logic                          alloc_rsp_err_o,
  output logic                          mem_req_val_o,
  input  logic                          mem_req_rdy_i,
  output logic                          mem_req_is_write_o,
  output logic [DATA_W-1:0]             mem_req_addr_o,
  output logic [DATA_W-1:0]             mem_req_data_o,
  input  logic                          mem_rsp_val_i,
  output logic                          mem_rsp_rdy_o,
  input  logic [DATA_W-1:0]             mem_rsp_data_i
);

  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
  localparam int CNT_W      = $clog2(BLOCK_WORDS + 1);
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DRAIN   = 2'd2,
    RESPOND = 2'd3
  } state_e;

  state_e                               state;
  state_e                               state_nxt;
  logic                                 is_write;
  logic [DATA_W-1:0]                    base_addr;
  logic [BLOCK_WORDS-1:0][DATA_W-1:0]   wbuf;
  logic [BLOCK_WORDS-1:0][DATA_W-1:0]   result;
  logic [CNT_W-1:0]                     beats;
  logic [CNT_W-1:0]                     issued;
  logic [CNT_W-1:0]                     received;
  logic [OUT_W-1:0]                     outstanding;

  logic                                 in_write;
  logic                                 in_block;
  logic                                 misaligned;
  logic                                 accept;
  logic                                 req_fire;
  logic                                 rsp_fire;
  logic [CNT_W-1:0]                     issued_nxt;
  logic [CNT_W-1:0]                     received_nxt;
  logic [DATA_W-1:0]                    wdata;

  // Request decode; LOAD_WORD and every spare code fall through to a word load.
  always_comb begin
    in_write = 1'b0;
    in_block = 1'b0;
    case (alloc_req_op_i)
      STORE_WORD:  in_write = 1'b1;
      LOAD_BLOCK:  in_block = 1'b1;
      STORE_BLOCK: begin
        in_write = 1'b1;
        in_block = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FALAFEL_LSU_ALIGN_CHECK_EN
  logic err_q;

  assign misaligned = |alloc_req_addr_i[BYTE_SHIFT-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end
  end

  assign alloc_rsp_err_o = err_q;
`else
  assign misaligned      = 1'b0;
  assign alloc_rsp_err_o = 1'b0;
`endif

  // Memory-side handshakes are decoded outside the FSM process so the
  // next-state logic can look at post-handshake counter values without a
  // combinational loop through the valid/ready outputs.
  assign mem_req_val_o = (state == ISSUE) && (issued < beats) &&
                         (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign mem_rsp_rdy_o = (state == ISSUE) || (state == DRAIN);
  assign req_fire      = mem_req_val_o && mem_req_rdy_i;
  assign rsp_fire      = mem_rsp_val_i && mem_rsp_rdy_o;
  assign issued_nxt    = issued + CNT_W'(req_fire);
  assign received_nxt  = received + CNT_W'(rsp_fire);
  assign accept        = alloc_req_val_i && alloc_req_rdy_o;

  always_comb begin
    wdata = '0;
    if (is_write) begin
      for (int k = 0; k < BLOCK_WORDS; k++) begin
        if (issued == CNT_W'(k)) wdata = wbuf[k];
      end
    end
  end

  assign mem_req_is_write_o = is_write;
  assign mem_req_addr_o     = base_addr + (DATA_W'(issued) << BYTE_SHIFT);
  assign mem_req_data_o     = wdata;
  assign alloc_rsp_word_o   = result[0];
  assign alloc_rsp_block_o  = result;

  always_comb begin
    state_nxt       = state;
    alloc_req_rdy_o = 1'b0;
    alloc_rsp_val_o = 1'b0;
    case (state)
      IDLE: begin
        alloc_req_rdy_o = 1'b1;
        if (alloc_req_val_i) state_nxt = misaligned ? RESPOND : ISSUE;
      end
      ISSUE: begin
        // Last request and last response in the same cycle skip DRAIN.
        if (issued_nxt == beats) begin
          state_nxt = (received_nxt == beats) ? RESPOND : DRAIN;
        end
      end
      DRAIN: begin
        if (received_nxt == beats) state_nxt = RESPOND;
      end
      RESPOND: begin
        alloc_rsp_val_o = 1'b1;
        if (alloc_rsp_rdy_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      base_addr   <= '0;
      wbuf        <= '0;
      result      <= '0;
      beats       <= '0;
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
    end else begin
      state       <= state_nxt;
      issued      <= issued_nxt;
      received    <= received_nxt;
      outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(rsp_fire);

      // Write responses are consumed but never touch the result buffer, so
      // stores leave the previous load's data visible.
      if (rsp_fire && !is_write) begin
        for (int k = 0; k < BLOCK_WORDS; k++) begin
          if (received == CNT_W'(k)) result[k] <= mem_rsp_data_i;
        end
      end

      if (accept) begin
        is_write    <= in_write;
        base_addr   <= alloc_req_addr_i;
        beats       <= in_block ? CNT_W'(BLOCK_WORDS) : CNT_W'(1);
        wbuf        <= in_block ? alloc_req_block_i
                                : (BLOCK_WORDS*DATA_W)'(alloc_req_word_i);
        issued      <= '0;
        received    <= '0;
        outstanding <= '0;
      end
    end
  end

  illegal_op_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    accept |-> (alloc_req_op_i inside {LOAD_WORD, STORE_WORD, LOAD_BLOCK, STORE_BLOCK}));

endmodule

`default_nettype wire

// File: tb/tb_falafel_lsu_burst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_falafel_lsu_burst
// Purpose  : Scoreboarded bench for falafel_lsu_burst (DATA_W=32,
//            BLOCK_WORDS=4, MAX_OUTSTANDING=2) with a latency/stall-controlled
//            memory responder and a word-addressed reference memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_falafel_lsu_burst;
  import falafel_lsu_pkg::*;

  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int MAXO = 2;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              alloc_req_val_i;
  logic              alloc_req_rdy_o;
  lsu_op_e           alloc_req_op_i;
  logic [DW-1:0]     alloc_req_addr_i;
  logic [DW-1:0]     alloc_req_word_i;
  logic [BW*DW-1:0]  alloc_req_block_i;
  logic              alloc_rsp_val_o;
  logic              alloc_rsp_rdy_i;
  logic [DW-1:0]     alloc_rsp_word_o;
  logic [BW*DW-1:0]  alloc_rsp_block_o;
  logic              alloc_rsp_err_o;
  logic              mem_req_val_o;
  logic              mem_req_rdy_i;
  logic              mem_req_is_write_o;
  logic [DW-1:0]     mem_req_addr_o;
  logic [DW-1:0]     mem_req_data_o;
  logic              mem_rsp_val_i;
  logic              mem_rsp_rdy_o;
  logic [DW-1:0]     mem_rsp_data_i;

  always #5 clk = ~clk;

  falafel_lsu_burst #(.DATA_W(DW), .BLOCK_WORDS(BW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .alloc_req_val_i(alloc_req_val_i), .alloc_req_rdy_o(alloc_req_rdy_o),
    .alloc_req_op_i(alloc_req_op_i), .alloc_req_addr_i(alloc_req_addr_i),
    .alloc_req_word_i(alloc_req_word_i), .alloc_req_block_i(alloc_req_block_i),
    .alloc_rsp_val_o(alloc_rsp_val_o), .alloc_rsp_rdy_i(alloc_rsp_rdy_i),
    .alloc_rsp_word_o(alloc_rsp_word_o), .alloc_rsp_block_o(alloc_rsp_block_o),
    .alloc_rsp_err_o(alloc_rsp_err_o),
    .mem_req_val_o(mem_req_val_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_is_write_o(mem_req_is_write_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_data_o(mem_req_data_o),
    .mem_rsp_val_i(mem_rsp_val_i), .mem_rsp_rdy_o(mem_rsp_rdy_o),
    .mem_rsp_data_i(mem_rsp_data_i)
  );

  typedef struct { logic w; logic [31:0] addr; logic [31:0] data; } mreq_t;
  typedef struct { lsu_op_e op; logic [31:0] word; logic [BW*32-1:0] block; logic err; } rsp_t;
  typedef struct { logic [31:0] data; int due; } pend_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  mreq_t exp_mem_q[$];
  rsp_t  exp_rsp_q[$];
  pend_t pend_q[$];
  int    req_hs_cyc[$];
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] model_res [BW];
  int rdy_pct = 100, rsp_pct = 100, ack_pct = 100, lat_min = 1, lat_max = 1;
  int out_cnt = 0, max_out = 0, req_hs_cnt = 0, rsp_done = 0;
  int acc_cyc = 0, first_val_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Memory responder: accepts beats, answers in order after a random latency.
  initial begin
    mem_req_rdy_i = 1'b0; mem_rsp_val_i = 1'b0; mem_rsp_data_i = '0;
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        if (mem_rsp_val_i && mem_rsp_rdy_o) begin
          void'(pend_q.pop_front());
          out_cnt--;
        end
        if (mem_req_val_o && mem_req_rdy_i) begin
          mreq_t e;
          pend_t p;
          req_hs_cnt++;
          req_hs_cyc.push_back(cyc);
          if (exp_mem_q.size() == 0) begin
            check("mem_req_unexpected", {mem_req_is_write_o, mem_req_addr_o}, 0);
          end else begin
            e = exp_mem_q.pop_front();
            check("mem_req", {mem_req_is_write_o, mem_req_addr_o, mem_req_data_o},
                  {e.w, e.addr, e.data});
          end
          if (mem_req_is_write_o) begin
            resp_mem[mem_req_addr_o] = mem_req_data_o;
            p.data = $urandom;
          end else begin
            p.data = resp_mem.exists(mem_req_addr_o) ? resp_mem[mem_req_addr_o] : fill(mem_req_addr_o);
          end
          p.due = cyc + $urandom_range(lat_max, lat_min);
          pend_q.push_back(p);
          out_cnt++;
          if (out_cnt > max_out) max_out = out_cnt;
          check("outstanding_le_max", (out_cnt <= MAXO), 1);
        end
      end
      @(posedge clk); #1;
      mem_req_rdy_i = ($urandom_range(99) < rdy_pct);
      if (pend_q.size() > 0 && pend_q[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
        mem_rsp_val_i  = 1'b1;
        mem_rsp_data_i = pend_q[0].data;
      end else begin
        mem_rsp_val_i  = 1'b0;
        mem_rsp_data_i = $urandom;
      end
    end
  end

  initial begin
    alloc_rsp_rdy_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      alloc_rsp_rdy_i = ($urandom_range(99) < ack_pct);
    end
  end

  // Response monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni && alloc_rsp_val_o) begin
        if (first_val_cyc < 0) first_val_cyc = cyc;
        if (alloc_rsp_rdy_i) begin
          if (exp_rsp_q.size() == 0) begin
            check("alloc_rsp_unexpected", 1, 0);
          end else begin
            rsp_t e;
            e = exp_rsp_q.pop_front();
            check("rsp_err", alloc_rsp_err_o, e.err);
            if (e.op != LOAD_BLOCK) check("rsp_word", alloc_rsp_word_o, e.word);
            if (e.op != LOAD_WORD)  check("rsp_block", alloc_rsp_block_o, e.block);
          end
          rsp_done++;
        end
      end
    end
  end

  // Reference model: computes the expected beats and response for one op.
  task automatic prep_op(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] word,
                         input logic [BW*32-1:0] blk, input bit expect_rsp);
    bit is_w, is_b, mis;
    int n;
    rsp_t r;
    is_w = (op == STORE_WORD) || (op == STORE_BLOCK);
    is_b = (op == LOAD_BLOCK) || (op == STORE_BLOCK);
    n    = is_b ? BW : 1;
    mis  = 1'b0;
`ifdef FALAFEL_LSU_ALIGN_CHECK_EN
    mis  = (addr[1:0] != 2'b00);
`endif
    if (!mis) begin
      for (int i = 0; i < n; i++) begin
        mreq_t m;
        m.addr = addr + 32'(i * 4);
        m.w    = is_w;
        if (is_w) begin
          m.data = is_b ? blk[i*32 +: 32] : word;
          ref_mem[m.addr] = m.data;
        end else begin
          m.data = 32'h0;
          model_res[i] = ref_mem.exists(m.addr) ? ref_mem[m.addr] : fill(m.addr);
        end
        exp_mem_q.push_back(m);
      end
    end
    r.op = op; r.err = mis; r.word = model_res[0];
    for (int i = 0; i < BW; i++) r.block[i*32 +: 32] = model_res[i];
    if (expect_rsp) exp_rsp_q.push_back(r);
  endtask

  task automatic drive_req(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] word,
                           input logic [BW*32-1:0] blk);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    first_val_cyc     = -1;
    alloc_req_val_i   = 1'b1;
    alloc_req_op_i    = op;
    alloc_req_addr_i  = addr;
    alloc_req_word_i  = word;
    alloc_req_block_i = blk;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (alloc_req_rdy_o) begin
        acc_cyc = cyc;
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      check("req_accept_timeout", 0, 1);
      finish_sim();
    end
    @(posedge clk); #1;
    alloc_req_val_i = 1'b0;
  endtask

  task automatic do_op(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] word,
                       input logic [BW*32-1:0] blk);
    int start;
    bit done;
    start = rsp_done;
    done  = 1'b0;
    prep_op(op, addr, word, blk, 1'b1);
    drive_req(op, addr, word, blk);
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk); #1;
      if (rsp_done > start) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      check("rsp_timeout", 0, 1);
      finish_sim();
    end
  endtask

  task automatic zero_wait();
    rdy_pct = 100; rsp_pct = 100; ack_pct = 100; lat_min = 1; lat_max = 1;
  endtask

  initial begin
    int n0;
    bit hit;
    logic [BW*32-1:0] blk;
    rst_ni = 1'b0; alloc_req_val_i = 1'b0; alloc_req_op_i = LOAD_WORD;
    alloc_req_addr_i = '0; alloc_req_word_i = '0; alloc_req_block_i = '0;
    for (int i = 0; i < BW; i++) model_res[i] = 32'h0;
    zero_wait();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy",     alloc_req_rdy_o, 1);
    check("rst_rsp_val",     alloc_rsp_val_o, 0);
    check("rst_mem_req_val", mem_req_val_o, 0);
    check("rst_mem_rsp_rdy", mem_rsp_rdy_o, 0);
    check("rst_rsp_block",   alloc_rsp_block_o, 0);
    check("rst_mem_addr",    {mem_req_addr_o, mem_req_data_o, mem_req_is_write_o, alloc_rsp_err_o}, 0);
    rst_ni = 1'b1;

    // Word load latency with a zero-wait memory.
    resp_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100]  = 32'hDEAD_BEEF;
    do_op(LOAD_WORD, 32'h100, 0, 0);
    check("lw_latency", first_val_cyc - acc_cyc, 3);
    check("lw_data", alloc_rsp_word_o, 32'hDEAD_BEEF);

    // Block load issues one beat per cycle when memory never stalls.
    n0 = req_hs_cyc.size();
    do_op(LOAD_BLOCK, 32'h2000, 0, 0);
    for (int i = 1; i < BW; i++) check("b2b_gap", req_hs_cyc[n0+i] - req_hs_cyc[n0+i-1], 1);

    // Slow memory: outstanding must saturate at MAX_OUTSTANDING, not exceed it.
    lat_min = 3; lat_max = 3; max_out = 0;
    do_op(LOAD_BLOCK, 32'h200, 0, 0);
    check("peak_outstanding", max_out, MAXO);

    // Store block wrapping the address space, then read it back.
    zero_wait();
    do_op(STORE_BLOCK, 32'hFFFF_FFFC, 0, {32'h44, 32'h33, 32'h22, 32'h11});
    do_op(LOAD_BLOCK,  32'hFFFF_FFFC, 0, 0);
    do_op(STORE_WORD,  32'h300, 32'hCAFE_F00D, 0);
    do_op(LOAD_WORD,   32'h300, 0, 0);

    // Misaligned word load.
    n0 = req_hs_cnt;
    do_op(LOAD_WORD, 32'h102, 0, 0);
`ifdef FALAFEL_LSU_ALIGN_CHECK_EN
    check("misalign_no_mem", req_hs_cnt - n0, 0);
    check("misalign_err_latency", first_val_cyc - acc_cyc, 1);
`else
    check("misalign_passthrough", req_hs_cnt - n0, 1);
`endif

    // Reset after the second beat of a 4-beat load.
    lat_min = 3; lat_max = 3;
    n0 = req_hs_cnt;
    hit = 1'b0;
    prep_op(LOAD_BLOCK, 32'h400, 0, 0, 1'b0);
    drive_req(LOAD_BLOCK, 32'h400, 0, 0);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (req_hs_cnt >= n0 + 2) begin
        hit = 1'b1;
        break;
      end
    end
    check("reset_test_two_beats", hit, 1);
    @(posedge clk); #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_req_rdy", alloc_req_rdy_o, 1);
    check("midrst_outputs", {mem_req_val_o, mem_rsp_rdy_o, alloc_rsp_val_o, alloc_rsp_err_o,
                             mem_req_is_write_o, mem_req_addr_o, mem_req_data_o}, 0);
    check("midrst_result", alloc_rsp_block_o, 0);
    exp_mem_q.delete();
    for (int i = 0; i < BW; i++) model_res[i] = 32'h0;
    @(negedge clk); #1;
    pend_q.delete();
    out_cnt = 0;
    @(posedge clk); #2;
    rst_ni = 1'b1;
    do_op(LOAD_BLOCK, 32'h400, 0, 0);

    // Randomised traffic with stalls on every channel.
    rdy_pct = 60; rsp_pct = 60; ack_pct = 70; lat_min = 1; lat_max = 4;
    for (int n = 0; n < 40; n++) begin
      lsu_op_e op;
      logic [31:0] a;
      op = lsu_op_e'($urandom_range(3, 0));
      a  = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(3, 0) * 4)
                                       : 32'h1000 + 32'($urandom_range(31, 0) * 4);
      if ($urandom_range(7, 0) == 0) a = a + 32'($urandom_range(3, 1));
      for (int i = 0; i < BW; i++) blk[i*32 +: 32] = $urandom;
      do_op(op, a, $urandom, blk);
    end

    check("scoreboard_drained", {32'(exp_mem_q.size()), 32'(exp_rsp_q.size())}, 0);
    finish_sim();
  end

endmodule

`default_nettype wire
